// File: rtl/sha_msg_schedule_if.sv
// Bundle between the message feeder (master), the schedule stage (slave) and the
// SHA main loop, which reads the ml_* round outputs.
interface sha_msg_schedule_if #(parameter int WORD_W = 64);
   logic              start;
   logic              mode;
   logic              abort;
   logic              hold;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic              ml_enable;
   logic              ml_mode;
   logic [WORD_W-1:0] ml_w;
   logic [WORD_W-1:0] ml_k;
   logic [6:0]        ml_round;
   logic              ml_last;
   logic              busy;

   modport master (
      output start, mode, abort, hold, in_valid, in_word,
      input  in_ready, ml_enable, ml_mode, ml_w, ml_k, ml_round, ml_last, busy
   );

   modport slave (
      input  start, mode, abort, hold, in_valid, in_word,
      output in_ready, ml_enable, ml_mode, ml_w, ml_k, ml_round, ml_last, busy
   );
endinterface

// File: rtl/sha_msg_schedule.sv
// SHA-256/512 message schedule: 16 serial words in, one W_t/K_t per cycle out, one cycle after
// the word is accepted or computed; hold freezes everything and deasserts in_ready.
module sha_msg_schedule #(
   parameter int WORD_W = 64
) (
   input logic               clk,
   input logic               rst,
   sha_msg_schedule_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   // SHA-256 constants are the upper halves of the first 64 SHA-512 constants.
   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [31:0] sig0_256(input logic [31:0] x);
      return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1_256(input logic [31:0] x);
      return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [63:0] sig0_512(input logic [63:0] x);
      return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] sig1_512(input logic [63:0] x);
      return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
   endfunction

   logic [1:0]        state_q, state_d;
   logic              mode_q, mode_d;
   logic [6:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] win_q [16];
   logic [WORD_W-1:0] win_d [16];
   logic              en_q, en_d;
   logic              last_q, last_d;
   logic [WORD_W-1:0] w_q, w_d;
   logic [WORD_W-1:0] k_q, k_d;
   logic [6:0]        rnd_q, rnd_d;

   logic              accept;
   logic              issue;
   logic [6:0]        last_idx;
   logic [31:0]       sum256;
   logic [WORD_W-1:0] in_masked;
   logic [WORD_W-1:0] sched_w;
   logic [WORD_W-1:0] new_w;
   logic [63:0]       k_rom;

   assign last_idx  = mode_q ? 7'd79 : 7'd63;
   assign accept    = (state_q == S_LOAD) && !bus.hold && bus.in_valid;
   // cnt_q == last_idx + 1 marks the drain cycle that keeps busy up through the last round
   assign issue     = accept || ((state_q == S_RUN) && !bus.hold && (cnt_q <= last_idx));
   assign in_masked = mode_q ? bus.in_word : {{(WORD_W-32){1'b0}}, bus.in_word[31:0]};
   assign sum256    = sig1_256(win_q[14][31:0]) + win_q[9][31:0]
                    + sig0_256(win_q[1][31:0]) + win_q[0][31:0];
   assign sched_w   = mode_q ? (sig1_512(win_q[14]) + win_q[9] + sig0_512(win_q[1]) + win_q[0])
                             : {{(WORD_W-32){1'b0}}, sum256};
   assign new_w     = accept ? in_masked : sched_w;
   assign k_rom     = (cnt_q < 7'd80) ? K512[cnt_q] : 64'd0;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      en_d    = 1'b0;
      w_d     = w_q;
      k_d     = k_q;
      rnd_d   = rnd_q;
      last_d  = bus.hold ? last_q : 1'b0;
      if (bus.abort) begin
         state_d = S_IDLE;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start) begin
               state_d = S_LOAD;
               mode_d  = bus.mode;
               cnt_d   = 7'd0;
            end
            S_LOAD: if (accept && (cnt_q == 7'd15)) state_d = S_RUN;
            S_RUN:  if (cnt_q > last_idx) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
         if (issue) begin
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = new_w;
            cnt_d     = cnt_q + 7'd1;
            en_d      = 1'b1;
            w_d       = new_w;
            k_d       = mode_q ? k_rom : {32'd0, k_rom[63:32]};
            rnd_d     = cnt_q;
            last_d    = (cnt_q == last_idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         cnt_q   <= 7'd0;
         en_q    <= 1'b0;
         last_q  <= 1'b0;
         w_q     <= '0;
         k_q     <= '0;
         rnd_q   <= 7'd0;
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         last_q  <= last_d;
         w_q     <= w_d;
         k_q     <= k_d;
         rnd_q   <= rnd_d;
         win_q   <= win_d;
      end
   end

   assign bus.in_ready  = (state_q == S_LOAD) && !bus.hold;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.ml_enable = en_q;
   assign bus.ml_mode   = mode_q;
   assign bus.ml_w      = w_q;
   assign bus.ml_k      = k_q;
   assign bus.ml_round  = rnd_q;
   assign bus.ml_last   = last_q;
endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: directed "abc" blocks plus random blocks with stalls, abort and
// mid-run reset, checked against hand values and an independent schedule model.
module tb_sha_msg_schedule;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha_msg_schedule_if #(.WORD_W(64)) bus ();
   sha_msg_schedule #(.WORD_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [63:0] msg     [16];
   logic [63:0] ref_w   [80];
   logic [63:0] obs_w   [80];
   logic [63:0] obs_k   [80];
   logic [6:0]  obs_rnd [80];
   logic        obs_last[80];
   logic        obs_mode[80];
   int          obs_cyc [80];
   int          n_en;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   task automatic build_ref(input logic m);
      logic [63:0] a, b;
      logic [31:0] c, d;
      for (int t = 0; t < 16; t++) ref_w[t] = m ? msg[t] : {32'd0, msg[t][31:0]};
      for (int t = 16; t < 80; t++) begin
         if (m) begin
            a = rr64(ref_w[t-15], 1) ^ rr64(ref_w[t-15], 8) ^ (ref_w[t-15] >> 7);
            b = rr64(ref_w[t-2], 19) ^ rr64(ref_w[t-2], 61) ^ (ref_w[t-2] >> 6);
            ref_w[t] = a + b + ref_w[t-7] + ref_w[t-16];
         end else begin
            c = rr32(ref_w[t-15][31:0], 7) ^ rr32(ref_w[t-15][31:0], 18) ^ (ref_w[t-15][31:0] >> 3);
            d = rr32(ref_w[t-2][31:0], 17) ^ rr32(ref_w[t-2][31:0], 19) ^ (ref_w[t-2][31:0] >> 10);
            ref_w[t] = {32'd0, c + d + ref_w[t-7][31:0] + ref_w[t-16][31:0]};
         end
      end
   endtask

   task automatic set_abc(input logic m);
      for (int i = 0; i < 16; i++) msg[i] = 64'd0;
      msg[0]  = m ? 64'h6162638000000000 : 64'h0000000061626380;
      msg[15] = 64'h18;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_en"},    bus.ml_enable, 0);
      check({tag, "_mode"},  bus.ml_mode,   0);
      check({tag, "_w"},     bus.ml_w,      0);
      check({tag, "_k"},     bus.ml_k,      0);
      check({tag, "_round"}, bus.ml_round,  0);
      check({tag, "_last"},  bus.ml_last,   0);
      check({tag, "_busy"},  bus.busy,      0);
      check({tag, "_rdy"},   bus.in_ready,  0);
   endtask

   // Drives one block; stop_at >= 0 aborts (or resets, if use_rst) once that round is seen.
   task automatic run_block(input logic m, input bit stall, input bit poke,
                            input int stop_at, input bit use_rst);
      int  cyc, idx, hold_left;
      bit  done, acc, prev_hold;
      cyc = 0; idx = 0; hold_left = 0; done = 0; n_en = 0;
      for (int i = 0; i < 80; i++) begin
         obs_w[i] = '0; obs_k[i] = '0; obs_rnd[i] = '0;
         obs_last[i] = 1'b0; obs_mode[i] = 1'b0; obs_cyc[i] = 0;
      end
      bus.start = 1'b1; bus.mode = m; bus.hold = 1'b0; bus.in_valid = 1'b0; bus.abort = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      #1;
      if (!stall) begin
         check("busy_after_start", bus.busy, 1);
         check("rdy_after_start", bus.in_ready, 1);
      end
      while (!done && cyc < 600) begin
         if (stall && hold_left == 0 && $urandom_range(0, 7) == 0) hold_left = 3;
         bus.hold = (hold_left != 0);
         if (hold_left != 0) hold_left--;
         bus.in_valid = (idx < 16) && (!stall || $urandom_range(0, 2) != 0);
         bus.in_word  = (idx < 16) ? msg[idx] : 64'd0;
         bus.start    = poke && ($urandom_range(0, 3) == 0);
         bus.mode     = poke ? ~m : m;
         #1;
         acc = bus.in_valid && bus.in_ready;
         prev_hold = bus.hold;
         @(posedge clk); #1;
         cyc++;
         if (acc) idx++;
         if (prev_hold) check("en_after_hold", bus.ml_enable, 0);
         if (bus.ml_enable && n_en < 80) begin
            obs_w[n_en] = bus.ml_w; obs_k[n_en] = bus.ml_k; obs_rnd[n_en] = bus.ml_round;
            obs_last[n_en] = bus.ml_last; obs_mode[n_en] = bus.ml_mode; obs_cyc[n_en] = cyc;
            n_en++;
            if (bus.ml_last) done = 1;
            if (stop_at >= 0 && int'(bus.ml_round) == stop_at) begin
               done = 1;
               bus.start = 1'b0; bus.hold = 1'b0; bus.in_valid = 1'b0;
               if (use_rst) begin
                  #2 rst = 1'b1;
                  #1 check_reset("rst_mid");
                  @(posedge clk); #1;
                  rst = 1'b0;
               end else begin
                  bus.abort = 1'b1;
                  @(posedge clk); #1;
                  bus.abort = 1'b0;
                  check("abort_en", bus.ml_enable, 0);
                  check("abort_busy", bus.busy, 0);
                  check("abort_rdy", bus.in_ready, 0);
               end
            end
         end
      end
      check("block_done", done, 1);
      bus.start = 1'b0; bus.hold = 1'b0; bus.in_valid = 1'b0;
      if (stop_at < 0) begin
         @(posedge clk); #1;
         check("busy_end", bus.busy, 0);
         check("en_end", bus.ml_enable, 0);
      end
   endtask

   task automatic check_block(input logic m, input bit nostall);
      int nr;
      nr = m ? 80 : 64;
      check("n_rounds", n_en, nr);
      for (int i = 0; i < n_en; i++) begin
         check($sformatf("round%0d", i), obs_rnd[i], i);
         check($sformatf("w%0d", i), obs_w[i], ref_w[i]);
         check($sformatf("last%0d", i), obs_last[i], (i == nr - 1));
         check($sformatf("mode%0d", i), obs_mode[i], m);
      end
      if (m) begin
         check("k512_0", obs_k[0], 64'h428a2f98d728ae22);
         check("k512_63", obs_k[63], 64'hc67178f2e372532b);
         check("k512_79", obs_k[79], 64'h6c44198c4a475817);
      end else begin
         check("k256_0", obs_k[0], 64'h428a2f98);
         check("k256_16", obs_k[16], 64'he49b69c1);
         check("k256_63", obs_k[63], 64'hc67178f2);
      end
      if (nostall) begin
         check("span_load", obs_cyc[15] - obs_cyc[0], 15);
         check("span_run", obs_cyc[nr-1] - obs_cyc[15], nr - 16);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0;
      bus.hold = 1'b0; bus.in_valid = 1'b0; bus.in_word = '0;
      repeat (2) @(posedge clk);
      #1 check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      set_abc(0); build_ref(0);
      run_block(0, 0, 0, -1, 0);
      check_block(0, 1);
      check("abc256_w16", obs_w[16], 64'h61626380);
      check("abc256_w17", obs_w[17], 64'h000f0000);

      set_abc(1); build_ref(1);
      run_block(1, 0, 0, -1, 0);
      check_block(1, 1);
      check("abc512_w16", obs_w[16], 64'h6162638000000000);
      check("abc512_w17", obs_w[17], 64'h00030000000000c0);

      set_abc(0); build_ref(0);
      run_block(0, 1, 0, -1, 0);
      check_block(0, 0);
      set_abc(1); build_ref(1);
      run_block(1, 1, 0, -1, 0);
      check_block(1, 0);

      set_rand(); build_ref(0);
      run_block(0, 1, 1, -1, 0);
      check_block(0, 0);
      for (int i = 0; i < n_en; i++) check($sformatf("upper%0d", i), obs_w[i][63:32], 0);
      set_rand(); build_ref(1);
      run_block(1, 1, 1, -1, 0);
      check_block(1, 0);

      set_abc(0); build_ref(0);
      run_block(0, 0, 0, 30, 0);
      check("abort_rounds", n_en, 31);
      set_rand(); build_ref(1);
      run_block(1, 0, 0, -1, 0);
      check_block(1, 1);

      set_rand(); build_ref(0);
      run_block(0, 0, 0, 40, 1);
      check("rst_rounds", n_en, 41);
      set_rand(); build_ref(1);
      run_block(1, 1, 0, -1, 0);
      check_block(1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
